// File: rtl/wb_periph16_if.sv
// Wishbone classic bus bundle between the intercon slave port and wb_periph16.
interface wb_periph16_if;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic [31:0] wb_adr_i;
  logic [1:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_ack_o;

  modport master (
    output wb_dat_i, wb_adr_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_dat_i, wb_adr_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_periph16.sv
// 16-bit Wishbone classic slave: LED register, seven-segment word register and a
// 32-bit timer with compare match, pending flag and level interrupt.
module wb_periph16 #(
  parameter logic [7:0]  LED_RESET = 8'h00,
  parameter logic [15:0] SEG_RESET = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  wb_periph16_if.slave wb,
  output logic [7:0]  leds_o,
  output logic [15:0] seg_word_o,
  output logic        irq_o
);

  localparam logic [2:0] A_LED    = 3'd0;
  localparam logic [2:0] A_SEG    = 3'd1;
  localparam logic [2:0] A_TMR_LO = 3'd2;
  localparam logic [2:0] A_TMR_HI = 3'd3;
  localparam logic [2:0] A_CMP_LO = 3'd4;
  localparam logic [2:0] A_CMP_HI = 3'd5;
  localparam logic [2:0] A_CTRL   = 3'd6;
  localparam logic [2:0] A_STATUS = 3'd7;

  logic [7:0]  led_reg, led_next;
  logic [15:0] seg_reg, seg_next;
  logic [31:0] counter_reg, counter_next;
  logic [31:0] cmp_reg, cmp_next;
  logic [2:0]  ctrl_reg, ctrl_next;
  logic        pend_reg, pend_next;
  logic [15:0] shadow_reg, shadow_next;
  logic        irq_reg, irq_next;
  logic        ack_reg, ack_next;
  logic [15:0] dat_o_reg, dat_o_next;

  logic        req, wr, rd, match;
  logic [2:0]  addr;
  logic [15:0] lane_mask;
  logic [15:0] rdata;
  logic [15:0] led_merged;
  logic        unused_adr;

  assign unused_adr = ^{wb.wb_adr_i[31:4], wb.wb_adr_i[0]};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      assign lane_mask[gi*8 +: 8] = {8{wb.wb_sel_i[gi]}};
    end
  endgenerate

  function automatic logic [15:0] merge16(input logic [15:0] old_v,
                                          input logic [15:0] new_v,
                                          input logic [15:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // ack itself masks the request so a held strobe gets a wait state between acks
  assign req   = wb.wb_cyc_i & wb.wb_stb_i & ~ack_reg;
  assign wr    = req & wb.wb_we_i;
  assign rd    = req & ~wb.wb_we_i;
  assign addr  = wb.wb_adr_i[3:1];
  assign match = ctrl_reg[0] && (counter_reg == cmp_reg);
  assign led_merged = merge16({8'h00, led_reg}, wb.wb_dat_i, lane_mask);

  always_comb begin
    rdata = 16'h0000;
    case (addr)
      A_LED:    rdata = {8'h00, led_reg};
      A_SEG:    rdata = seg_reg;
      A_TMR_LO: rdata = counter_reg[15:0];
      A_TMR_HI: rdata = shadow_reg;
      A_CMP_LO: rdata = cmp_reg[15:0];
      A_CMP_HI: rdata = cmp_reg[31:16];
      A_CTRL:   rdata = {13'h0000, ctrl_reg};
      A_STATUS: rdata = {15'h0000, pend_reg};
      default:  rdata = 16'h0000;
    endcase
  end

  always_comb begin
    led_next     = led_reg;
    seg_next     = seg_reg;
    counter_next = counter_reg;
    cmp_next     = cmp_reg;
    ctrl_next    = ctrl_reg;
    pend_next    = pend_reg;
    shadow_next  = shadow_reg;

    if (wr) begin
      case (addr)
        A_LED:    led_next = led_merged[7:0];
        A_SEG:    seg_next = merge16(seg_reg, wb.wb_dat_i, lane_mask);
        A_CMP_LO: cmp_next[15:0]  = merge16(cmp_reg[15:0], wb.wb_dat_i, lane_mask);
        A_CMP_HI: cmp_next[31:16] = merge16(cmp_reg[31:16], wb.wb_dat_i, lane_mask);
        A_CTRL:   if (wb.wb_sel_i[0]) ctrl_next = wb.wb_dat_i[2:0];
        default:  ;
      endcase
    end

    if (rd && addr == A_TMR_LO) begin
      shadow_next = counter_reg[31:16];
    end

    // A bus load takes over the counter for this cycle: no count, no match
    if (wr && addr == A_TMR_LO) begin
      counter_next[15:0] = merge16(counter_reg[15:0], wb.wb_dat_i, lane_mask);
    end else if (wr && addr == A_TMR_HI) begin
      counter_next[31:16] = merge16(counter_reg[31:16], wb.wb_dat_i, lane_mask);
    end else if (match) begin
      counter_next = ctrl_reg[2] ? 32'h0000_0000 : counter_reg + 32'd1;
    end else if (ctrl_reg[0]) begin
      counter_next = counter_reg + 32'd1;
    end

    // Set beats clear when a match lands on the same edge as a W1C
    if (wr && addr == A_STATUS && wb.wb_sel_i[0] && wb.wb_dat_i[0]) begin
      pend_next = 1'b0;
    end
    if (match && !(wr && (addr == A_TMR_LO || addr == A_TMR_HI))) begin
      pend_next = 1'b1;
    end
  end

  assign ack_next   = req;
  assign dat_o_next = req ? rdata : 16'h0000;
  assign irq_next   = pend_reg & ctrl_reg[1];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      led_reg     <= LED_RESET;
      seg_reg     <= SEG_RESET;
      counter_reg <= 32'h0000_0000;
      cmp_reg     <= 32'hFFFF_FFFF;
      ctrl_reg    <= 3'b000;
      pend_reg    <= 1'b0;
      shadow_reg  <= 16'h0000;
      irq_reg     <= 1'b0;
      ack_reg     <= 1'b0;
      dat_o_reg   <= 16'h0000;
    end else begin
      led_reg     <= led_next;
      seg_reg     <= seg_next;
      counter_reg <= counter_next;
      cmp_reg     <= cmp_next;
      ctrl_reg    <= ctrl_next;
      pend_reg    <= pend_next;
      shadow_reg  <= shadow_next;
      irq_reg     <= irq_next;
      ack_reg     <= ack_next;
      dat_o_reg   <= dat_o_next;
    end
  end

  assign wb.wb_ack_o = ack_reg;
  assign wb.wb_dat_o = dat_o_reg;
  assign leds_o      = led_reg;
  assign seg_word_o  = seg_reg;
  assign irq_o       = irq_reg;

endmodule

// File: tb/tb_wb_periph16.sv
// Directed bench for wb_periph16: register table, timer shadow, compare/irq, W1C race, wrap, held strobe.
module tb_wb_periph16;

  logic        clk_i;
  logic        rst_i;
  logic [7:0]  leds_o;
  logic [15:0] seg_word_o;
  logic        irq_o;
  int          n_checks;
  int          n_errors;
  logic [15:0] rd_val;

  wb_periph16_if bus ();

  wb_periph16 dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wb         (bus),
    .leds_o     (leds_o),
    .seg_word_o (seg_word_o),
    .irq_o      (irq_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [2:0]  a;
    logic [1:0]  sel;
    logic [15:0] wd;
    logic [15:0] rexp;
    logic [7:0]  leds;
    logic [15:0] seg;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One access: request edge, ack sampled after it, ack must drop after the next edge.
  task automatic bus_xfer(input logic we, input logic [2:0] a, input logic [1:0] sel,
                          input logic [15:0] wd, output logic [15:0] rd);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = {16'hABCD, 12'h000, a, 1'b0};
    bus.wb_sel_i = sel;
    bus.wb_dat_i = wd;
    @(posedge clk_i);
    #1;
    chk("ack_high", {31'd0, bus.wb_ack_o}, 32'd1);
    rd = bus.wb_dat_o;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    @(posedge clk_i);
    #1;
    chk("ack_low", {31'd0, bus.wb_ack_o}, 32'd0);
    $display("%s reg=%0d sel=%b wdat=%h rdat=%h", we ? "WR" : "RD", a, sel, wd, rd);
  endtask

  task automatic wr(input logic [2:0] a, input logic [1:0] sel, input logic [15:0] wd);
    logic [15:0] dummy;
    bus_xfer(1'b1, a, sel, wd, dummy);
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [15:0] exp);
    logic [15:0] v;
    bus_xfer(1'b0, a, 2'b11, 16'h0000, v);
    chk(name, {16'd0, v}, {16'd0, exp});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    vecs[0]  = '{1'b1, 3'd0, 2'b01, 16'hFF5A, 16'h0000, 8'h5A, 16'h0000};
    vecs[1]  = '{1'b1, 3'd0, 2'b10, 16'hA700, 16'h0000, 8'h5A, 16'h0000};
    vecs[2]  = '{1'b0, 3'd0, 2'b11, 16'h0000, 16'h005A, 8'h5A, 16'h0000};
    vecs[3]  = '{1'b1, 3'd1, 2'b11, 16'h1234, 16'h0000, 8'h5A, 16'h1234};
    vecs[4]  = '{1'b1, 3'd1, 2'b10, 16'hBEEF, 16'h0000, 8'h5A, 16'hBE34};
    vecs[5]  = '{1'b0, 3'd1, 2'b11, 16'h0000, 16'hBE34, 8'h5A, 16'hBE34};
    vecs[6]  = '{1'b1, 3'd1, 2'b01, 16'hBEEF, 16'h0000, 8'h5A, 16'hBEEF};
    vecs[7]  = '{1'b0, 3'd1, 2'b11, 16'h0000, 16'hBEEF, 8'h5A, 16'hBEEF};
    vecs[8]  = '{1'b1, 3'd4, 2'b11, 16'hA55A, 16'h0000, 8'h5A, 16'hBEEF};
    vecs[9]  = '{1'b0, 3'd4, 2'b11, 16'h0000, 16'hA55A, 8'h5A, 16'hBEEF};
    vecs[10] = '{1'b1, 3'd5, 2'b01, 16'h0F0F, 16'h0000, 8'h5A, 16'hBEEF};
    vecs[11] = '{1'b0, 3'd5, 2'b11, 16'h0000, 16'hFF0F, 8'h5A, 16'hBEEF};
    vecs[12] = '{1'b1, 3'd6, 2'b01, 16'hFFFE, 16'h0000, 8'h5A, 16'hBEEF};
    vecs[13] = '{1'b0, 3'd6, 2'b11, 16'h0000, 16'h0006, 8'h5A, 16'hBEEF};
    vecs[14] = '{1'b1, 3'd6, 2'b11, 16'h0000, 16'h0000, 8'h5A, 16'hBEEF};
    vecs[15] = '{1'b0, 3'd7, 2'b11, 16'h0000, 16'h0000, 8'h5A, 16'hBEEF};
    vecs[16] = '{1'b0, 3'd2, 2'b11, 16'h0000, 16'h0000, 8'h5A, 16'hBEEF};
    vecs[17] = '{1'b0, 3'd3, 2'b11, 16'h0000, 16'h0000, 8'h5A, 16'hBEEF};

    // Reset held with a live strobe
    rst_i        = 1'b0;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = 32'h0000_0000;
    bus.wb_sel_i = 2'b11;
    bus.wb_dat_i = 16'h0000;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ack", {31'd0, bus.wb_ack_o}, 32'd0);
    chk("rst_dat", {16'd0, bus.wb_dat_o}, 32'd0);
    chk("rst_leds", {24'd0, leds_o}, 32'h00);
    chk("rst_seg", {16'd0, seg_word_o}, 32'h0000);
    chk("rst_irq", {31'd0, irq_o}, 32'd0);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rd_chk("rst_cmp_hi", 3'd5, 16'hFFFF);
    rd_chk("rst_cmp_lo", 3'd4, 16'hFFFF);

    // Register map table
    for (int i = 0; i < 18; i++) begin
      bus_xfer(vecs[i].we, vecs[i].a, vecs[i].sel, vecs[i].wd, rd_val);
      if (!vecs[i].we) chk($sformatf("vec%0d_rdat", i), {16'd0, rd_val}, {16'd0, vecs[i].rexp});
      chk($sformatf("vec%0d_leds", i), {24'd0, leds_o}, {24'd0, vecs[i].leds});
      chk($sformatf("vec%0d_seg", i), {16'd0, seg_word_o}, {16'd0, vecs[i].seg});
    end

    // Shadowed high half: latched on the low read, not live
    wr(3'd2, 2'b11, 16'hFFFE);
    wr(3'd3, 2'b11, 16'h0000);
    wr(3'd6, 2'b01, 16'h0001);
    repeat (3) @(posedge clk_i);
    #1;
    rd_chk("tmr_lo_first", 3'd2, 16'h0002);
    repeat (10) @(posedge clk_i);
    #1;
    wr(3'd3, 2'b11, 16'h1234);
    rd_chk("tmr_hi_shadow", 3'd3, 16'h0001);
    rd_chk("tmr_lo_live", 3'd2, 16'h0011);
    rd_chk("tmr_hi_relatch", 3'd3, 16'h1234);

    // Compare match with auto-clear and interrupt
    wr(3'd6, 2'b01, 16'h0000);
    wr(3'd4, 2'b11, 16'd20);
    wr(3'd5, 2'b11, 16'h0000);
    wr(3'd2, 2'b11, 16'h0000);
    wr(3'd3, 2'b11, 16'h0000);
    wr(3'd7, 2'b01, 16'h0001);
    wr(3'd6, 2'b01, 16'h0007);
    repeat (19) @(posedge clk_i);
    #1;
    chk("irq_before_match", {31'd0, irq_o}, 32'd0);
    @(posedge clk_i);
    #1;
    chk("irq_at_match_edge", {31'd0, irq_o}, 32'd0);
    @(posedge clk_i);
    #1;
    chk("irq_after_match", {31'd0, irq_o}, 32'd1);
    rd_chk("autoclr_counter", 3'd2, 16'h0001);
    rd_chk("pend_set", 3'd7, 16'h0001);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = 1'b1;
    bus.wb_adr_i = 32'h0000_000E;
    bus.wb_sel_i = 2'b01;
    bus.wb_dat_i = 16'h0001;
    @(posedge clk_i);
    #1;
    chk("w1c_ack", {31'd0, bus.wb_ack_o}, 32'd1);
    chk("irq_lag_clear", {31'd0, irq_o}, 32'd1);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    @(posedge clk_i);
    #1;
    chk("irq_cleared", {31'd0, irq_o}, 32'd0);
    rd_chk("pend_cleared", 3'd7, 16'h0000);

    // W1C landing on the exact match edge loses to the set
    wr(3'd6, 2'b01, 16'h0000);
    wr(3'd4, 2'b11, 16'd10);
    wr(3'd5, 2'b11, 16'h0000);
    wr(3'd2, 2'b11, 16'h0000);
    wr(3'd3, 2'b11, 16'h0000);
    wr(3'd7, 2'b01, 16'h0001);
    wr(3'd6, 2'b01, 16'h0001);
    repeat (9) @(posedge clk_i);
    #1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = 1'b1;
    bus.wb_adr_i = 32'h0000_000E;
    bus.wb_sel_i = 2'b01;
    bus.wb_dat_i = 16'h0001;
    @(posedge clk_i);
    #1;
    chk("race_ack", {31'd0, bus.wb_ack_o}, 32'd1);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    @(posedge clk_i);
    #1;
    rd_chk("race_pend_kept", 3'd7, 16'h0001);
    wr(3'd7, 2'b01, 16'h0001);
    rd_chk("pend_w1c_plain", 3'd7, 16'h0000);
    wr(3'd7, 2'b01, 16'h0000);

    // Counter wrap does not flag
    wr(3'd6, 2'b01, 16'h0000);
    wr(3'd4, 2'b11, 16'd5);
    wr(3'd5, 2'b11, 16'h0000);
    wr(3'd2, 2'b11, 16'hFFFF);
    wr(3'd3, 2'b11, 16'hFFFF);
    wr(3'd6, 2'b01, 16'h0001);
    rd_chk("wrap_no_pend", 3'd7, 16'h0000);
    rd_chk("wrap_lo", 3'd2, 16'h0002);
    rd_chk("wrap_hi", 3'd3, 16'h0000);
    wr(3'd6, 2'b01, 16'h0000);
    wr(3'd7, 2'b01, 16'h0001);

    // Held strobe on LED: ack every second cycle, data zero between acks
    wr(3'd0, 2'b01, 16'h00A5);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = 32'h0000_0000;
    bus.wb_sel_i = 2'b11;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_i);
      #1;
      chk($sformatf("held_ack%0d", i + 1), {31'd0, bus.wb_ack_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("held_dat%0d", i + 1), {16'd0, bus.wb_dat_o}, (i % 2 == 0) ? 32'h00A5 : 32'd0);
      $display("HELD cycle=%0d ack=%b dat=%h", i + 1, bus.wb_ack_o, bus.wb_dat_o);
    end
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    @(posedge clk_i);
    #1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
